alu: RTL and testbench

- 32-bit integer ALU for the ARM-subset core, executing one micro-op per accepted request.
- Takes two operands and a 5-bit micro-op from decode, and returns a registered result plus the [Z,C,N,V] condition flags to writeback and condition logic.
- Latency is one cycle. The flags are architectural state held inside the block.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shifter.sv | 41 ++++
 rtl/alu.sv | 132 +++++++++++++
 tb/tb_alu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU: micro-op codes, flag bit positions and widths.
// Codes 9-12 only execute when the top is built with ALU_EXT_OPS_EN defined.
package alu_pkg;

  localparam int ALU_WIDTH      = 32;
  localparam int ALU_SHAMT_BITS = 8;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_XOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_ORR = 5'd9;
  localparam logic [4:0] UOP_ADC = 5'd10;
  localparam logic [4:0] UOP_SBC = 5'd11;
  localparam logic [4:0] UOP_ASR = 5'd12;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    SHIFT_LSL,
    SHIFT_LSR,
    SHIFT_ASR
  } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter (LSL / LSR / ASR) producing the result and the
// carry flag: the last bit shifted out, or the incoming carry when sh is zero.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int SHAMT_BITS = ALU_SHAMT_BITS
) (
  input  logic [WIDTH-1:0]      lhs_i,
  input  logic [SHAMT_BITS-1:0] sh_i,
  input  shift_mode_e           mode_i,
  input  logic                  c_i,
  output logic [WIDTH-1:0]      result_o,
  output logic                  c_o
);

  logic                  fill;
  logic [WIDTH:0]        left_w;
  logic signed [WIDTH+1:0] right_w;

  // Guard bits on each side capture the last bit shifted out; the top bit of
  // right_w is the fill value, so shifts past the width saturate to it.
  assign fill    = (mode_i == SHIFT_ASR) & lhs_i[WIDTH-1];
  assign left_w  = {1'b0, lhs_i} << sh_i;
  assign right_w = $signed({fill, lhs_i, 1'b0}) >>> sh_i;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    result_o = right_w[WIDTH:1];
    c_o      = right_w[0];
    if (mode_i == SHIFT_LSL) begin
      result_o = left_w[WIDTH-1:0];
      c_o      = left_w[WIDTH];
    end
    if (sh_i == '0) begin
      c_o = c_i;
    end
  end

endmodule

// File: rtl/alu.sv
// Single-cycle 32-bit ALU with registered result and {Z,C,N,V} flags.
// Define ALU_EXT_OPS_EN to add ORR/ADC/SBC/ASR; otherwise codes 9-12 act as NOP.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = ALU_WIDTH,
  parameter int SHAMT_BITS = ALU_SHAMT_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] LHS,
  input  logic [WIDTH-1:0] RHS,
  input  logic [4:0]       uop,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             out_valid
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q;

  logic             sub_sel, carry_in;
  shift_mode_e      shift_mode;
  logic [WIDTH-1:0] rhs_op, result, shift_res;
  logic [WIDTH:0]   sum;
  logic             add_v, shift_c, wr_out, upd_zn;

  always_comb begin
    sub_sel    = 1'b0;
    carry_in   = 1'b0;
    shift_mode = SHIFT_LSL;
    case (uop)
      UOP_SUB, UOP_CMP: begin
        sub_sel  = 1'b1;
        carry_in = 1'b1;
      end
      UOP_LSR: shift_mode = SHIFT_LSR;
`ifdef ALU_EXT_OPS_EN
      UOP_ADC: carry_in = flags_q[FLAG_C];
      UOP_SBC: begin
        sub_sel  = 1'b1;
        carry_in = flags_q[FLAG_C];
      end
      UOP_ASR: shift_mode = SHIFT_ASR;
`endif
      default: ;
    endcase
  end

  // Subtraction is LHS + ~RHS + 1, so the adder's carry out is NOT borrow.
  assign rhs_op = sub_sel ? ~RHS : RHS;
  assign sum    = {1'b0, LHS} + {1'b0, rhs_op} + {{WIDTH{1'b0}}, carry_in};
  assign add_v  = (LHS[WIDTH-1] == rhs_op[WIDTH-1]) && (sum[WIDTH-1] != LHS[WIDTH-1]);

  alu_shifter #(
    .WIDTH      (WIDTH),
    .SHAMT_BITS (SHAMT_BITS)
  ) u_shifter (
    .lhs_i    (LHS),
    .sh_i     (RHS[SHAMT_BITS-1:0]),
    .mode_i   (shift_mode),
    .c_i      (flags_q[FLAG_C]),
    .result_o (shift_res),
    .c_o      (shift_c)
  );

  always_comb begin
    out_d   = out_q;
    flags_d = flags_q;
    result  = '0;
    wr_out  = 1'b1;
    upd_zn  = 1'b1;
    case (uop)
`ifdef ALU_EXT_OPS_EN
      UOP_ADC, UOP_SBC,
`endif
      UOP_ADD, UOP_SUB, UOP_CMP: begin
        result          = sum[WIDTH-1:0];
        wr_out          = (uop != UOP_CMP);
        flags_d[FLAG_C] = sum[WIDTH];
        flags_d[FLAG_V] = add_v;
      end
`ifdef ALU_EXT_OPS_EN
      UOP_ASR,
`endif
      UOP_LSL, UOP_LSR: begin
        result          = shift_res;
        flags_d[FLAG_C] = shift_c;
      end
      UOP_AND: result = LHS & RHS;
      UOP_XOR: result = LHS ^ RHS;
      UOP_MOV: result = RHS;
`ifdef ALU_EXT_OPS_EN
      UOP_ORR: result = LHS | RHS;
`endif
      default: begin
        wr_out = 1'b0;
        upd_zn = 1'b0;
      end
    endcase
    if (upd_zn) begin
      flags_d[FLAG_Z] = (result == '0);
      flags_d[FLAG_N] = result[WIDTH-1];
    end
    if (wr_out) begin
      out_d = result;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q   <= out_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out       = out_q;
  assign flags     = flags_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold sequences and
// randomized requests compared against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] lhs, rhs;
  logic [4:0]  uop;
  logic [31:0] out;
  logic [3:0]  flags;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_out;
  logic [3:0]  m_flags;

  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  always #5 clk = ~clk;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .LHS       (lhs),
    .RHS       (rhs),
    .uop       (uop),
    .out       (out),
    .flags     (flags),
    .out_valid (out_valid)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic [3:0]  exp_flags;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC] = '{
    '{5'd1,  32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0000},
    '{5'd2,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 4'b1100},
    '{5'd3,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 4'b1100},
    '{5'd4,  32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b0110},
    '{5'd5,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0011},
    '{5'd8,  32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 4'b0001},
    '{5'd31, 32'hDEAD_BEEF, 32'h0000_0000, 32'h1234_5678, 4'b0001},
    '{5'd0,  32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 4'b0001},
    '{5'd1,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1000},
    '{5'd6,  32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 4'b0000},
    '{5'd7,  32'h8000_0000, 32'h0000_0001, 32'h4000_0000, 4'b0000},
    '{5'd7,  32'h8000_0000, 32'h0000_0020, 32'h0000_0000, 4'b1100},
    '{5'd6,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 4'b0100},
    '{5'd6,  32'h0000_0003, 32'h0000_0028, 32'h0000_0000, 4'b1000},
    '{5'd6,  32'h0000_0001, 32'h0000_0020, 32'h0000_0000, 4'b1100},
    '{5'd6,  32'hC000_0000, 32'h0000_0102, 32'h0000_0000, 4'b1100},
    '{5'd1,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100},
    '{5'd1,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011},
    '{5'd2,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010},
    '{5'd2,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0101},
    '{5'd3,  32'hFF00_FF00, 32'hF0F0_F0F0, 32'hF000_F000, 4'b0111},
    '{5'd7,  32'h0000_00F0, 32'h0000_0104, 32'h0000_000F, 4'b0001},
    '{5'd7,  32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001, 4'b0101},
    '{5'd7,  32'h0000_0001, 32'h0000_0021, 32'h0000_0000, 4'b1001},
    '{5'd5,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1100}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model_step(input logic [4:0] op_in, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, u;
    longint          sa, sb, s, cin;
    logic [31:0]     res;
    logic            c, v;
    logic [4:0]      op;
    bit              wr, nop, ext;
    int              sh;
    op  = op_in;
    ua  = a;
    ub  = b;
    sa  = $signed(a);
    sb  = $signed(b);
    c   = m_flags[FLAG_C];
    v   = m_flags[FLAG_V];
    res = m_out;
    wr  = 1'b1;
    nop = 1'b0;
    sh  = int'(b[7:0]);
    ext = 1'b0;
`ifdef ALU_EXT_OPS_EN
    ext = 1'b1;
`endif
    if (!ext && op >= 5'd9 && op <= 5'd12) op = UOP_NOP;
    case (op)
      UOP_ADD, UOP_ADC: begin
        cin = (op == UOP_ADC) ? longint'(m_flags[FLAG_C]) : 0;
        u   = ua + ub + cin;
        res = u[31:0];
        c   = (u >= 64'h1_0000_0000);
        s   = sa + sb + cin;
        v   = (s > SMAX) || (s < SMIN);
      end
      UOP_SUB, UOP_CMP, UOP_SBC: begin
        cin = (op == UOP_SBC) ? 1 - longint'(m_flags[FLAG_C]) : 0;
        u   = ua - ub - cin;
        res = u[31:0];
        c   = (ua >= ub + cin);
        s   = sa - sb - cin;
        v   = (s > SMAX) || (s < SMIN);
        wr  = (op != UOP_CMP);
      end
      UOP_AND: res = a & b;
      UOP_XOR: res = a ^ b;
      UOP_ORR: res = a | b;
      UOP_MOV: res = b;
      UOP_LSL: begin
        if (sh == 0) res = a;
        else if (sh <= 32) begin
          res = (sh == 32) ? 32'h0 : a << sh;
          c   = a[32-sh];
        end else begin
          res = 32'h0;
          c   = 1'b0;
        end
      end
      UOP_LSR: begin
        if (sh == 0) res = a;
        else if (sh <= 32) begin
          res = (sh == 32) ? 32'h0 : a >> sh;
          c   = a[sh-1];
        end else begin
          res = 32'h0;
          c   = 1'b0;
        end
      end
      UOP_ASR: begin
        if (sh == 0) res = a;
        else if (sh < 32) begin
          res = $signed(a) >>> sh;
          c   = a[sh-1];
        end else begin
          res = {32{a[31]}};
          c   = a[31];
        end
      end
      default: nop = 1'b1;
    endcase
    if (!nop) begin
      m_flags[FLAG_Z] = (res == 32'h0);
      m_flags[FLAG_N] = res[31];
      m_flags[FLAG_C] = c;
      m_flags[FLAG_V] = v;
      if (wr) m_out = res;
    end
  endtask

  task automatic drive_req(input logic vld, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    @(negedge clk);
    in_valid = vld;
    uop      = op;
    lhs      = a;
    rhs      = b;
    if (vld) model_step(op, a, b);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_uop();
    int r;
    r = $urandom_range(0, 17);
    if (r == 16) return 5'd31;
    if (r == 17) return 5'd20;
    return 5'(r);
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    logic [31:0] a, b, held_out;
    logic [4:0]  op;
    logic        vld;
    logic [3:0]  held_flags;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    uop      = 5'd0;
    lhs      = '0;
    rhs      = '0;
    m_out    = '0;
    m_flags  = '0;

    #3;
    check("reset out", out, 32'h0);
    check("reset flags", {28'h0, flags}, 32'h0);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive_req(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d out", i), out, vecs[i].exp_out);
      check($sformatf("vec%0d flags", i), {28'h0, flags}, {28'h0, vecs[i].exp_flags});
      check($sformatf("vec%0d out_valid", i), {31'h0, out_valid}, 32'h1);
    end

    // Asynchronous reset between edges while ADDs stream back to back.
    drive_req(1'b1, UOP_ADD, 32'd5, 32'd6);
    check("pre-reset add out", out, 32'd11);
    @(negedge clk);
    uop      = UOP_ADD;
    lhs      = 32'd7;
    rhs      = 32'd8;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midop reset out", out, 32'h0);
    check("midop reset flags", {28'h0, flags}, 32'h0);
    check("midop reset out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("reset held out", out, 32'h0);
    check("reset held out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    m_out    = '0;
    m_flags  = '0;

    // Idle cycles hold result and flags with out_valid low.
    drive_req(1'b1, UOP_SUB, 32'h0000_0003, 32'h0000_0007);
    check("hold setup out", out, 32'hFFFF_FFFC);
    check("hold setup flags", {28'h0, flags}, 32'h0000_0002);
    held_out   = out;
    held_flags = flags;
    for (int i = 0; i < 3; i++) begin
      a = $urandom();
      drive_req(1'b0, UOP_ADD, a, 32'h1);
      check($sformatf("idle%0d out", i), out, held_out);
      check($sformatf("idle%0d flags", i), {28'h0, flags}, {28'h0, held_flags});
      check($sformatf("idle%0d out_valid", i), {31'h0, out_valid}, 32'h0);
    end

    for (int i = 0; i < 600; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      op  = pick_uop();
      a   = pick_operand();
      b   = pick_operand();
      if ((op == UOP_LSL || op == UOP_LSR || op == UOP_ASR) && $urandom_range(0, 3) != 0)
        b[7:0] = 8'($urandom_range(0, 40));
      drive_req(vld, op, a, b);
      check($sformatf("rand%0d op%0d out", i, op), out, m_out);
      check($sformatf("rand%0d op%0d flags", i, op), {28'h0, flags}, {28'h0, m_flags});
      check($sformatf("rand%0d out_valid", i), {31'h0, out_valid}, {31'h0, vld});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
